// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: operand pair in, resolved result out.
interface csa_resolver_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic                 valid_i;
  logic                 ready_o;
  logic [DATA_SIZE-1:0] sum_i;
  logic [DATA_SIZE-1:0] carry_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DATA_SIZE-1:0] result_o;
  logic                 busy_o;

  modport slave (
    input  valid_i, sum_i, carry_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

  modport master (
    output valid_i, sum_i, carry_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/csa_resolver.sv
// Chunk-serial carry-propagate adder resolving a carry-save (sum, carry) pair.
// Optional macro CSA_RESOLVER_SAT_EN saturates signed overflow instead of wrapping.
module csa_resolver #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned CHUNK     = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  csa_resolver_if.slave bus
);
  localparam int unsigned    NUM_CHUNKS = DATA_SIZE / CHUNK;
  localparam int unsigned    K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [K_W-1:0] K_LAST     = K_W'(NUM_CHUNKS - 1);

  if (DATA_SIZE % CHUNK != 0) begin : g_chunk_check
    $error("csa_resolver: DATA_SIZE must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] sum_q;
  logic [DATA_SIZE-1:0] carry_q;
  logic [DATA_SIZE-1:0] result_q;
  logic [K_W-1:0]       k_q;
  logic                 cy_q;

  logic                 ready;
  logic                 valid;
  logic                 busy;
  logic                 accept;
  logic                 last_chunk;
  logic [CHUNK-1:0]     sum_chunk;
  logic [CHUNK-1:0]     carry_chunk;
  logic [CHUNK-1:0]     r;
  logic                 c;

  assign accept     = bus.valid_i && ready;
  assign last_chunk = (state_q == BUSY) && (k_q == K_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_i) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (bus.ready_i) state_d = bus.valid_i ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      BUSY: busy  = 1'b1;
      DONE: begin
        valid = 1'b1;
        ready = bus.ready_i;
      end
      default: ;
    endcase
  end

  // Chunk k of each operand is picked by a mux on k_q; one CHUNK-wide adder is shared.
  always_comb begin
    sum_chunk   = '0;
    carry_chunk = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (k_q == K_W'(i)) begin
        sum_chunk   = sum_q[i*CHUNK +: CHUNK];
        carry_chunk = carry_q[i*CHUNK +: CHUNK];
      end
    end
    {c, r} = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CHUNK{1'b0}}, cy_q};
  end

`ifdef CSA_RESOLVER_SAT_EN
  logic overflow;
  assign overflow = last_chunk
                 && (sum_q[DATA_SIZE-1] == carry_q[DATA_SIZE-1])
                 && (r[CHUNK-1] != sum_q[DATA_SIZE-1]);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      cy_q     <= 1'b0;
    end else if (accept) begin
      sum_q   <= bus.sum_i;
      carry_q <= bus.carry_i;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
        if (k_q == K_W'(i)) result_q[i*CHUNK +: CHUNK] <= r;
      end
`ifdef CSA_RESOLVER_SAT_EN
      // Overrides the partially written word with the signed extreme in the last cycle.
      if (overflow) begin
        result_q <= sum_q[DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                       : {1'b0, {(DATA_SIZE-1){1'b1}}};
      end
`endif
      cy_q <= c;
      k_q  <= k_q + K_W'(1);
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid;
  assign bus.busy_o   = busy;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed cases plus randomized traffic vs a reference model.
module tb_csa_resolver;
  localparam int unsigned DW   = 16;
  localparam int unsigned NRND = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  csa_resolver_if #(.DATA_SIZE(DW)) bus ();

  csa_resolver #(
    .DATA_SIZE(DW),
    .CHUNK    (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed integer addition, then wrap or clamp to the 16-bit range.
  function automatic logic [15:0] ref_add(input logic [15:0] s, input logic [15:0] c);
    int sv;
    sv = int'($signed(s)) + int'($signed(c));
`ifdef CSA_RESOLVER_SAT_EN
    if (sv > 32767)  return 16'h7FFF;
    if (sv < -32768) return 16'h8000;
`endif
    return sv[15:0];
  endfunction

  task automatic wait_valid(input string tag, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.valid_o && lat < 20) begin
      if (bus.busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus.valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [15:0] s, input logic [15:0] c,
                         input logic [15:0] exp, input string tag);
    int lat, bc;
    @(negedge clk);
    check({tag, "_ready"}, bus.ready_o, 32'd1);
    bus.valid_i = 1'b1;
    bus.sum_i   = s;
    bus.carry_i = c;
    bus.ready_i = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.sum_i   = 16'($urandom);
    bus.carry_i = 16'($urandom);
    wait_valid(tag, lat, bc);
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_busy"}, bc, 32'd4);
    check({tag, "_res"}, bus.result_o, exp);
    check({tag, "_rdy_done"}, bus.ready_o, 32'd0);
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    check({tag, "_vdrop"}, bus.valid_o, 32'd0);
  endtask

  initial begin
    int lat, bc;
    logic [15:0] held;
    logic [15:0] expq[$];
    int sent, recvd, cyc;
    logic in_fire, hold;
    logic [15:0] held_res;

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.sum_i   = '0;
    bus.carry_i = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready_o, 32'd1);
    check("rst_valid", bus.valid_o, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_busy", bus.busy_o, 32'd0);
    rst_n = 1'b1;

    run_one(16'h1234, 16'h0F0F, 16'h2143, "basic");
    run_one(16'h0FFF, 16'h0001, 16'h1000, "chain");
    run_one(16'hFFFF, 16'h0001, 16'h0000, "signs_differ");
`ifdef CSA_RESOLVER_SAT_EN
    run_one(16'h7FFF, 16'h0001, 16'h7FFF, "ovf_pos");
    run_one(16'h8000, 16'hFFFF, 16'h8000, "ovf_neg");
`else
    run_one(16'h7FFF, 16'h0001, 16'h8000, "ovf_pos");
    run_one(16'h8000, 16'hFFFF, 16'h7FFF, "ovf_neg");
`endif

    // Backpressure in DONE, then a back-to-back capture.
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.sum_i   = 16'h1111;
    bus.carry_i = 16'h2222;
    bus.ready_i = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    wait_valid("bp", lat, bc);
    check("bp_res", bus.result_o, 32'h3333);
    held = bus.result_o;
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_valid", bus.valid_o, 32'd1);
      check("bp_hold_res", bus.result_o, held);
      check("bp_hold_ready", bus.ready_o, 32'd0);
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.sum_i   = 16'h0003;
    bus.carry_i = 16'h0004;
    #1 check("b2b_ready", bus.ready_o, 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    check("b2b_busy", bus.busy_o, 32'd1);
    wait_valid("b2b", lat, bc);
    check("b2b_lat", lat, 32'd4);
    check("b2b_res", bus.result_o, 32'h0007);
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;

    // Reset while chunk 2 is being resolved.
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.sum_i   = 16'h1234;
    bus.carry_i = 16'h0F0F;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.valid_o, 32'd0);
    check("mrst_ready", bus.ready_o, 32'd1);
    check("mrst_result", bus.result_o, 32'd0);
    check("mrst_busy", bus.busy_o, 32'd0);
    @(negedge clk);
    check("mrst_valid2", bus.valid_o, 32'd0);
    rst_n = 1'b1;
    run_one(16'h0010, 16'h0020, 16'h0030, "post_rst");

    // Randomized traffic with random upstream gaps and downstream stalls.
    sent    = 0;
    recvd   = 0;
    cyc     = 0;
    in_fire = 1'b0;
    hold    = 1'b0;
    held_res = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    while ((sent < NRND || expq.size() > 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        check("rnd_hold_valid", bus.valid_o, 32'd1);
        check("rnd_hold_res", bus.result_o, held_res);
      end
      if (in_fire) bus.valid_i = 1'b0;
      if (!bus.valid_i && sent < NRND && $urandom_range(0, 2) != 0) begin
        bus.valid_i = 1'b1;
        bus.sum_i   = 16'($urandom);
        bus.carry_i = 16'($urandom);
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.valid_o && bus.ready_i) begin
        if (expq.size() == 0) check("rnd_dup", 32'd1, 32'd0);
        else check("rnd_res", bus.result_o, expq.pop_front());
        recvd++;
      end
      in_fire  = bus.valid_i && bus.ready_o;
      hold     = bus.valid_o && !bus.ready_i;
      held_res = bus.result_o;
      if (in_fire) begin
        expq.push_back(ref_add(bus.sum_i, bus.carry_i));
        sent++;
      end
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    check("rnd_sent", sent, NRND);
    check("rnd_recv", recvd, NRND);
    check("rnd_left", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
